// File: rtl/ahb_byte_master.sv
`default_nettype none
// ============================================================================
// Module   : ahb_byte_master
// Purpose  : Turns framed byte-stream commands into single AHB-Lite transfers.
//            Frame    : opcode, ADDR (4 bytes MSB first), [DATA (4 bytes MSB first)]
//            Response : status byte, then 4 HRDATA bytes (MSB first) on a good read.
// Revision : 1.0  initial release
// ============================================================================
module ahb_byte_master #(
  parameter int GAP_TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        RSTn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic        busy
);

  localparam int                CNT_W     = $clog2(GAP_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  GAP_LIMIT = CNT_W'(GAP_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  localparam logic [6:0] ST_OK    = 7'h00;
  localparam logic [6:0] ST_ERR   = 7'h01;
  localparam logic [6:0] ST_BADOP = 7'h03;
  localparam logic [6:0] ST_MISAL = 7'h04;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_WDATA   = 3'd2,
    S_ADDR_PH = 3'd3,
    S_DATA_PH = 3'd4,
    S_RESP    = 3'd5,
    S_RDATA   = 3'd6
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [6:0]       code_nx;

  logic             op_write;
  logic [1:0]       op_size;
  logic [31:0]      addr_sr;
  logic [31:0]      wdata_sr;
  logic [31:0]      rdata_sr;
  logic [1:0]       byte_cnt;
  logic [CNT_W-1:0] gap_cnt;
  logic [7:0]       status;
  logic             overrun;

  logic             last_byte;
  logic             bad_op;
  logic             misaligned;
  logic             ovr_rx;
  logic             enter_resp;
  logic             enter_aph;
  logic             in_frame;

  assign last_byte  = rx_valid && (byte_cnt == 2'd3);
  assign bad_op     = (rx_data[1:0] == 2'd3) || (rx_data[6:2] != 5'd0);
  // Alignment is judged on the final address byte, which is on rx_data right now.
  assign misaligned = ((op_size == 2'd1) && rx_data[0]) ||
                      ((op_size == 2'd2) && (rx_data[1:0] != 2'd0));
  assign in_frame   = (state == S_ADDR) || (state == S_WDATA);
  assign ovr_rx     = rx_valid && ((state == S_ADDR_PH) || (state == S_DATA_PH) ||
                                   (state == S_RESP)    || (state == S_RDATA));
  assign enter_resp = (state_nx == S_RESP)    && (state != S_RESP);
  assign enter_aph  = (state_nx == S_ADDR_PH) && (state != S_ADDR_PH);

  assign HTRANS   = (state == S_ADDR_PH) ? 2'b10 : 2'b00;
  assign HBURST   = 3'b000;
  assign HPROT    = 4'b0011;
  assign busy     = (state != S_IDLE);
  assign tx_valid = (state == S_RESP) || (state == S_RDATA);
  assign tx_data  = (state == S_RESP)  ? status :
                    (state == S_RDATA) ? rdata_sr[31:24] : 8'h00;

  // State register; async reset drops any address phase immediately.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state decode plus the status code to load on entry to RESP.
  always_comb begin
    state_nx = state;
    code_nx  = ST_OK;
    case (state)
      S_IDLE: begin
        if (rx_valid) begin
          if (bad_op) begin
            state_nx = S_RESP;
            code_nx  = ST_BADOP;
          end else begin
            state_nx = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (last_byte) begin
          if (misaligned) begin
            state_nx = S_RESP;
            code_nx  = ST_MISAL;
          end else if (op_write) begin
            state_nx = S_WDATA;
          end else begin
            state_nx = S_ADDR_PH;
          end
        end else if (!rx_valid && (gap_cnt == GAP_LIMIT)) begin
          state_nx = S_IDLE;
        end
      end
      S_WDATA: begin
        if (last_byte) begin
          state_nx = S_ADDR_PH;
        end else if (!rx_valid && (gap_cnt == GAP_LIMIT)) begin
          state_nx = S_IDLE;
        end
      end
      S_ADDR_PH: begin
        if (HREADY) state_nx = S_DATA_PH;
      end
      S_DATA_PH: begin
        if (HREADY) begin
          state_nx = S_RESP;
          code_nx  = HRESP ? ST_ERR : ST_OK;
        end
      end
      S_RESP: begin
        if (tx_ready) begin
          state_nx = (!op_write && (status[6:0] == ST_OK)) ? S_RDATA : S_IDLE;
        end
      end
      S_RDATA: begin
        if (tx_ready && (byte_cnt == 2'd3)) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Command capture: opcode fields, address and write-data shift registers.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      op_write <= 1'b0;
      op_size  <= 2'd0;
      addr_sr  <= 32'h0;
      wdata_sr <= 32'h0;
    end else begin
      if ((state == S_IDLE) && rx_valid) begin
        op_write <= rx_data[7];
        op_size  <= rx_data[1:0];
      end
      if ((state == S_ADDR) && rx_valid)  addr_sr  <= {addr_sr[23:0], rx_data};
      if ((state == S_WDATA) && rx_valid) wdata_sr <= {wdata_sr[23:0], rx_data};
    end
  end

  // Byte counter for frame fields and read-data bytes; gap counter for stalled frames.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      byte_cnt <= 2'd0;
      gap_cnt  <= '0;
    end else begin
      if (state_nx != state) begin
        byte_cnt <= 2'd0;
      end else if ((in_frame && rx_valid) || ((state == S_RDATA) && tx_ready)) begin
        byte_cnt <= byte_cnt + 2'd1;
      end
      if (in_frame && !rx_valid) gap_cnt <= gap_cnt + CNT_ONE;
      else                       gap_cnt <= '0;
    end
  end

  // AHB control/data outputs: address phase values latched on entry, HWDATA for the data phase.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      HADDR  <= 32'h0;
      HSIZE  <= 3'd0;
      HWRITE <= 1'b0;
      HWDATA <= 32'h0;
    end else begin
      if (enter_aph) begin
        HADDR  <= (state == S_ADDR) ? {addr_sr[23:0], rx_data} : addr_sr;
        HSIZE  <= {1'b0, op_size};
        HWRITE <= op_write;
      end
      if ((state == S_ADDR_PH) && HREADY && op_write) HWDATA <= wdata_sr;
    end
  end

  // Response path: read-data capture/shift, status load and overrun tracking.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      rdata_sr <= 32'h0;
      status   <= 8'h00;
      overrun  <= 1'b0;
    end else begin
      if ((state == S_DATA_PH) && HREADY && !HRESP && !op_write) begin
        rdata_sr <= HRDATA;
      end else if ((state == S_RDATA) && tx_ready) begin
        rdata_sr <= {rdata_sr[23:0], 8'h00};
      end
      // A byte dropped in the very cycle the status loads is still reported.
      if (enter_resp) begin
        status  <= {overrun | ovr_rx, code_nx};
        overrun <= 1'b0;
      end else if (ovr_rx) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ahb_byte_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_byte_master
// Purpose  : Self-checking bench for ahb_byte_master with a simple AHB slave
//            and a command-level reference model of the expected response.
// Revision : 1.0  initial release
// ============================================================================
module tb_ahb_byte_master;

  localparam int GAP = 40;

  logic        clk = 1'b0;
  logic        RSTn = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA = 32'h0;
  logic        HREADY = 1'b1;
  logic        HRESP = 1'b0;
  logic        busy;

  always #5 clk = ~clk;

  ahb_byte_master #(.GAP_TIMEOUT(GAP)) dut (
    .clk(clk), .RSTn(RSTn),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave configuration for the next transfer
  int          cfg_waits = 0;
  bit          cfg_err   = 1'b0;
  bit          cfg_write = 1'b0;
  bit          cfg_stall = 1'b0;
  logic [31:0] cfg_rdata = 32'h0;
  logic [31:0] cfg_wdata = 32'h0;
  logic [31:0] cfg_addr  = 32'h0;

  bit dp_on = 1'b0;
  int dp_left = 0;
  bit acc_n, done_n;

  // Behavioural AHB slave: wait states, two-cycle ERROR, address/data stability checks
  always begin
    @(negedge clk);
    acc_n  = (HTRANS == 2'b10) && HREADY;
    done_n = dp_on && HREADY;
    if (dp_on) begin
      check("dp_haddr", HADDR, cfg_addr);
      if (cfg_write) check("dp_hwdata", HWDATA, cfg_wdata);
    end
    @(posedge clk); #1;
    if (!RSTn)                      dp_on = 1'b0;
    else if (acc_n) begin           dp_on = 1'b1; dp_left = cfg_waits; end
    else if (done_n)                dp_on = 1'b0;
    else if (dp_on && dp_left > 0)  dp_left--;
    if (dp_on) begin
      HREADY = (dp_left == 0);
      HRESP  = cfg_err && (dp_left <= 1);
      HRDATA = (dp_left == 0) ? cfg_rdata : $urandom;
    end else begin
      HREADY = !cfg_stall;
      HRESP  = 1'b0;
      HRDATA = $urandom;
    end
  end

  logic [35:0] bus_q[$];
  logic [7:0]  tx_q[$];
  int          nonseq_cycles = 0;
  bit          hold_pend = 1'b0;
  logic [7:0]  hold_data = 8'h00;

  // Bus and response monitor: records accepted transfers and delivered bytes
  always @(negedge clk) begin
    if (HTRANS == 2'b10) begin
      nonseq_cycles++;
      if (HREADY) bus_q.push_back({HADDR, HSIZE, HWRITE});
    end
    if (hold_pend && RSTn) begin
      check("tx_hold_valid", 32'(tx_valid), 32'h1);
      check("tx_hold_data", 32'(tx_data), 32'(hold_data));
    end
    hold_pend = tx_valid && !tx_ready;
    hold_data = tx_data;
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  // Reference model: expected response bytes, frame length and whether a transfer happens
  logic [7:0] exp_q[$];
  task automatic model(input logic [7:0] op, input logic [31:0] addr, input bit err,
                       input logic [31:0] rd, input bit ovr, output bit xfer, output int nbytes);
    int   sz;
    bit   is_bad, is_mis;
    logic [7:0] st;
    sz     = int'(op) % 4;
    is_bad = (sz == 3) || (((int'(op) / 4) % 32) != 0);
    is_mis = ((sz == 1) && (addr % 2 != 0)) || ((sz == 2) && (addr % 4 != 0));
    exp_q.delete();
    if (is_bad) begin
      st = 8'h03; xfer = 1'b0; nbytes = 1;
    end else if (is_mis) begin
      st = 8'h04; xfer = 1'b0; nbytes = 5;
    end else begin
      xfer   = 1'b1;
      nbytes = (op >= 8'h80) ? 9 : 5;
      st     = err ? 8'h01 : 8'h00;
    end
    if (ovr) st = st + 8'h80;
    exp_q.push_back(st);
    if (xfer && (op < 8'h80) && !err)
      for (int i = 3; i >= 0; i--) exp_q.push_back(8'((rd >> (8 * i)) & 32'hff));
  endtask

  task automatic run_cmd(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input int waits, input bit err, input logic [31:0] rd,
                         input bit ovr_inject, input bit lat_chk, input int gap, input string tag);
    bit         xfer;
    int         nb;
    int         n0;
    logic [7:0] fr[$];
    model(op, addr, err, rd, ovr_inject, xfer, nb);
    cfg_waits = waits; cfg_err = err; cfg_rdata = rd;
    cfg_write = op[7]; cfg_wdata = data; cfg_addr = addr;
    fr.push_back(op);
    for (int i = 3; i >= 0; i--) fr.push_back(addr[8*i +: 8]);
    for (int i = 3; i >= 0; i--) fr.push_back(data[8*i +: 8]);
    tx_q.delete(); bus_q.delete(); n0 = nonseq_cycles;
    tx_ready = 1'b1;
    for (int i = 0; i < nb; i++) begin
      repeat ((gap < 0) ? int'($urandom_range(0, 3)) : gap) tick();
      send_byte(fr[i]);
    end
    if (lat_chk) begin
      check({tag, "_aph_htrans"}, 32'(HTRANS), 32'h2);
      check({tag, "_aph_haddr"}, HADDR, addr);
      check({tag, "_aph_hsize"}, 32'(HSIZE), 32'(op[1:0]));
      check({tag, "_aph_hwrite"}, 32'(HWRITE), 32'(op[7]));
      tick();
      check({tag, "_dph_htrans"}, 32'(HTRANS), 32'h0);
      check({tag, "_dph_txvalid"}, 32'(tx_valid), 32'h0);
      tick();
      check({tag, "_lat_txvalid"}, 32'(tx_valid), 32'h1);
      check({tag, "_lat_txdata"}, 32'(tx_data), 32'(exp_q[0]));
    end
    if (ovr_inject) begin
      tick();
      send_byte(8'h5A);
      tx_ready = 1'b0;
      repeat (10) tick();
      check({tag, "_ovr_valid"}, 32'(tx_valid), 32'h1);
      check({tag, "_ovr_status"}, 32'(tx_data), 32'(exp_q[0]));
      tx_ready = 1'b1;
    end
    for (int i = 0; i < 400 && busy; i++) begin
      if (gap < 0) tx_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    tx_ready = 1'b1;
    check({tag, "_done"}, 32'(busy), 32'h0);
    check({tag, "_ntx"}, 32'(tx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++)
      check($sformatf("%s_tx%0d", tag, i), 32'(tx_q[i]), 32'(exp_q[i]));
    check({tag, "_nxfer"}, 32'(bus_q.size()), 32'(xfer));
    check({tag, "_nonseq_cycles"}, 32'(nonseq_cycles - n0), 32'(xfer));
    if (xfer && bus_q.size() > 0) begin
      check({tag, "_haddr"}, bus_q[0][35:4], addr);
      check({tag, "_hsize_hwrite"}, 32'(bus_q[0][3:0]), 32'({1'b0, op[1:0], op[7]}));
    end
  endtask

  // Global time limit so the run always ends
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    check("rst_htrans", 32'(HTRANS), 32'h0);
    check("rst_haddr", HADDR, 32'h0);
    check("rst_hsize", 32'(HSIZE), 32'h0);
    check("rst_hwrite", 32'(HWRITE), 32'h0);
    check("rst_hwdata", HWDATA, 32'h0);
    check("rst_txdata", 32'(tx_data), 32'h0);
    check("rst_txvalid", 32'(tx_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("hburst", 32'(HBURST), 32'h0);
    check("hprot", 32'(HPROT), 32'h3);
    RSTn = 1'b1;
    tick();

    run_cmd(8'h02, 32'h0000_0010, 32'h0, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1, -1, "rd_word");
    run_cmd(8'h81, 32'h2000_0002, 32'h0000_ABCD, 3, 1'b0, 32'h5555_AAAA, 1'b0, 1'b0, -1, "wr_half");
    run_cmd(8'h02, 32'h4000_0000, 32'h0, 1, 1'b1, 32'h1234_5678, 1'b0, 1'b0, -1, "rd_err");
    run_cmd(8'h02, 32'h4000_0004, 32'h0, 0, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b0, -1, "rd_after_err");
    run_cmd(8'h43, 32'h0, 32'h0, 0, 1'b0, 32'h0, 1'b0, 1'b0, -1, "bad_op");
    run_cmd(8'h02, 32'h0000_0002, 32'h0, 0, 1'b0, 32'h0, 1'b0, 1'b0, -1, "misaligned");

    // Partial frame abandoned by the gap timeout
    tx_q.delete();
    send_byte(8'h02);
    send_byte(8'h00);
    repeat (GAP + 5) tick();
    check("gap_busy", 32'(busy), 32'h0);
    check("gap_notx", 32'(tx_q.size()), 32'h0);
    run_cmd(8'h82, 32'h0000_0100, 32'hCAFE_F00D, 0, 1'b0, 32'h0, 1'b0, 1'b0, GAP - 3, "slow_frame");

    run_cmd(8'h81, 32'h2000_0002, 32'h0000_ABCD, 3, 1'b0, 32'h0, 1'b1, 1'b0, -1, "overrun");
    run_cmd(8'h02, 32'h0000_0010, 32'h0, 0, 1'b0, 32'h0102_0304, 1'b0, 1'b0, -1, "after_ovr");

    for (int n = 0; n < 40; n++) begin
      logic [7:0]  op;
      logic [31:0] a;
      int          k;
      int          w;
      bit          e;
      k  = int'($urandom_range(0, 9));
      op = 8'($urandom);
      a  = $urandom;
      if (k == 0) begin
        if (op[6:2] == 5'd0 && op[1:0] != 2'd3) op[1:0] = 2'd3;
      end else begin
        op = {op[7], 5'd0, 2'($urandom_range(0, 2))};
        if (k == 1) begin
          if (op[1:0] == 2'd0) op[1:0] = 2'd1;
          a[0] = 1'b1;
        end else begin
          a = a & ~((32'd1 << op[1:0]) - 32'd1);
        end
      end
      w = int'($urandom_range(0, 3));
      e = (w > 0) && ($urandom_range(0, 3) == 0);
      run_cmd(op, a, $urandom, w, e, $urandom, 1'b0, 1'b0, -1, "rnd");
    end

    // Asynchronous reset while the address phase is being held
    cfg_stall = 1'b1;
    cfg_write = 1'b1;
    send_byte(8'h82);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    check("prerst_htrans", 32'(HTRANS), 32'h2);
    #2 RSTn = 1'b0;
    #1;
    check("arst_htrans", 32'(HTRANS), 32'h0);
    check("arst_haddr", HADDR, 32'h0);
    check("arst_hsize", 32'(HSIZE), 32'h0);
    check("arst_hwrite", 32'(HWRITE), 32'h0);
    check("arst_hwdata", HWDATA, 32'h0);
    check("arst_txvalid", 32'(tx_valid), 32'h0);
    check("arst_txdata", 32'(tx_data), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    tick();
    RSTn = 1'b1;
    cfg_stall = 1'b0;
    tick();
    tick();
    run_cmd(8'h02, 32'h0000_0020, 32'h0, 1, 1'b0, 32'h8765_4321, 1'b0, 1'b0, -1, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
